pcis_abd_rd_engine: RTL

PCIS_ABD_RD_ENGINE -- requirements
Module: pcis_abd_rd_engine

---
 rtl/pcis_abd_rd_engine_pkg.sv | 20 ++
 rtl/pcis_abd_rd_engine_fifo.sv | 37 +++
 rtl/pcis_abd_rd_engine.sv | 88 ++++++++
 3 files changed

// File: rtl/pcis_abd_rd_engine_pkg.sv
// AOSF1Types: shared ABD read-engine types and default buffer depths.
package AOSF1Types;
    localparam int ABD_ADDR_W = 64;
    localparam int ABD_MAX_DATA_W = 512;
    localparam int ABD_MAX_ID_W = 16;
    localparam int ABD_LOG_OUTSTANDING = 3;
    localparam int ABD_LOG_REQ_DEPTH = 3;
    typedef struct packed {
        logic                  valid;
        logic [ABD_ADDR_W-1:0] addr;
    } ABDReadReq;
    typedef struct packed {
        logic [ABD_MAX_DATA_W-1:0] data;
    } ABDInternalPacket;
    typedef struct packed {
        logic [ABD_MAX_ID_W-1:0] id;
        logic [8:0]              len;
        logic                    err;
    } ABDRdTrackEntry;
endpackage

// File: rtl/pcis_abd_rd_engine_fifo.sv
// HullFIFO: power-of-two synchronous FIFO; enq while full and deq while empty are ignored.
module HullFIFO #(
    parameter int W = 8,
    parameter int LOG_DEPTH = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enq,
    input  logic [W-1:0]       din,
    input  logic               deq,
    output logic [W-1:0]       dout,
    output logic               full,
    output logic               empty,
    output logic [LOG_DEPTH:0] count
);
    logic [W-1:0] mem [2**LOG_DEPTH];
    logic [LOG_DEPTH:0] wptr, rptr;
    logic do_enq, do_deq;
    assign count = wptr - rptr;
    assign full = count[LOG_DEPTH];
    assign empty = count == '0;
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;
    assign dout = mem[rptr[LOG_DEPTH-1:0]];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_enq) wptr <= wptr + (LOG_DEPTH+1)'(1);
            if (do_deq) rptr <= rptr + (LOG_DEPTH+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_enq) mem[wptr[LOG_DEPTH-1:0]] <= din;
    end
endmodule

// File: rtl/pcis_abd_rd_engine.sv
// pcis_abd_rd_engine: AXI read slave splitting bursts into per-beat ABD requests and returning beats in order.
module pcis_abd_rd_engine
    import AOSF1Types::*;
#(
    parameter int DATA_W = 512,
    parameter int ID_W = 6,
    parameter int LOG_OUTSTANDING = ABD_LOG_OUTSTANDING,
    parameter int LOG_REQ_DEPTH = ABD_LOG_REQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ID_W-1:0]          arid,
    input  logic [63:0]              araddr,
    input  logic [7:0]               arlen,
    input  logic [2:0]               arsize,
    input  logic                     arvalid,
    output logic                     arready,
    output logic [ID_W-1:0]          rid,
    output logic [DATA_W-1:0]        rdata,
    output logic [1:0]               rresp,
    output logic                     rlast,
    output logic                     rvalid,
    input  logic                     rready,
    output ABDReadReq                rd_req,
    output logic                     rd_req_valid,
    input  logic                     rd_req_accept,
    input  ABDInternalPacket         rd_resp,
    input  logic                     rd_resp_valid,
    output logic                     rd_resp_accept,
    output logic [LOG_OUTSTANDING:0] outstanding_bursts
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state;
    logic [63:0] addr;
    logic [8:0] left, beat;
    ABDRdTrackEntry ar_entry, head;
    ABDReadReq req_in;
    logic trk_full, trk_empty, req_full, req_empty;
    logic ar_fire, ar_err, r_fire;
    logic [LOG_REQ_DEPTH:0] unused_req_count;
    logic unused_bits;
    assign ar_err = araddr[OFF_W-1:0] != '0 || arsize != 3'(OFF_W);
    assign arready = rst_n && state == IDLE && !trk_full;
    assign ar_fire = arvalid && arready;
    assign ar_entry = '{id: ABD_MAX_ID_W'(arid), len: {1'b0, arlen} + 9'd1, err: ar_err};
    assign req_in = '{valid: 1'b1, addr: addr};
    assign rd_req_valid = rst_n && !req_empty;
    // Error bursts synthesise SLVERR beats locally and never touch the response stream.
    assign rvalid = rst_n && !trk_empty && (head.err || rd_resp_valid);
    assign rdata = head.err ? '0 : rd_resp.data[DATA_W-1:0];
    assign rresp = head.err ? 2'b10 : 2'b00;
    assign rid = head.id[ID_W-1:0];
    assign rlast = rst_n && !trk_empty && beat == head.len - 9'd1;
    assign r_fire = rvalid && rready;
    assign rd_resp_accept = r_fire && !head.err;
    assign unused_bits = ^{head.id, rd_resp};
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            addr <= '0;
            left <= '0;
            beat <= '0;
        end else begin
            if (r_fire) beat <= rlast ? '0 : beat + 9'd1;
            if (state == IDLE) begin
                if (ar_fire && !ar_err) begin
                    addr <= araddr;
                    left <= ar_entry.len;
                    state <= ISSUE;
                end
            end else if (!req_full) begin
                addr <= addr + 64'(BYTES);
                left <= left - 9'd1;
                if (left == 9'd1) state <= IDLE;
            end
        end
    end
    HullFIFO #(.W($bits(ABDRdTrackEntry)), .LOG_DEPTH(LOG_OUTSTANDING)) trk_fifo (
        .clk(clk), .reset_n(rst_n), .enq(ar_fire), .din(ar_entry), .deq(r_fire && rlast),
        .dout(head), .full(trk_full), .empty(trk_empty), .count(outstanding_bursts)
    );
    HullFIFO #(.W($bits(ABDReadReq)), .LOG_DEPTH(LOG_REQ_DEPTH)) req_fifo (
        .clk(clk), .reset_n(rst_n), .enq(state == ISSUE), .din(req_in), .deq(rd_req_accept),
        .dout(rd_req), .full(req_full), .empty(req_empty), .count(unused_req_count)
    );
endmodule
